// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, mux selects,
// trap causes, FSM states and the datapath control bundle.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_LW       = 4'h1;
  localparam logic [3:0] OP_SW       = 4'h2;
  localparam logic [3:0] OP_RTYPE_LO = 4'h3;
  localparam logic [3:0] OP_RTYPE_HI = 4'h8;
  localparam logic [3:0] OP_BEQ      = 4'h9;
  localparam logic [3:0] OP_BNE      = 4'hA;
  localparam logic [3:0] OP_J        = 4'hB;
  localparam logic [3:0] OP_INC      = 4'hC;
  localparam logic [3:0] OP_DEC      = 4'hD;
  localparam logic [3:0] OP_CLR      = 4'hE;
  localparam logic [3:0] OP_ILLEGAL  = 4'hF;

  localparam logic [1:0] ALU_RTYPE = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       inc;
    logic       dec;
    logic       clr;
    logic [1:0] alu_op;
  } ctrl_bundle_t;

  // Only the low nibble names an instruction; anything above it is reserved.
  function automatic logic illegal_op(input logic [3:0] op_lo, input logic upper_set);
    return upper_set || (op_lo == OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath/memory signal bundle. The controller side is master.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                zero;

  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;
  logic                reg_dst;
  logic                alu_src;
  logic                mem_to_reg;
  logic [1:0]          alu_op;
  logic                inc;
  logic                dec;
  logic                clr;
  logic                trap;
  logic [1:0]          trap_cause;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  opcode, mem_ready, zero,
    output ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
           reg_dst, alu_src, mem_to_reg, alu_op, inc, dec, clr,
           trap, trap_cause, instr_count
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
           reg_dst, alu_src, mem_to_reg, alu_op, inc, dec, clr,
           trap, trap_cause, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Combinational opcode decoder: latched opcode -> control bundle and class flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] op_q,
  output ctrl_bundle_t        bundle,
  output logic                is_load,
  output logic                is_store,
  output logic                is_branch_eq,
  output logic                is_branch_ne,
  output logic                is_jump,
  output logic                is_wb,
  output logic                illegal
);
  logic [3:0] op_lo;
  assign op_lo = op_q[3:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    bundle       = '0;
    is_load      = 1'b0;
    is_store     = 1'b0;
    is_branch_eq = 1'b0;
    is_branch_ne = 1'b0;
    is_jump      = 1'b0;
    is_wb        = 1'b0;
    illegal      = illegal_op(op_lo, (op_q >> 4) != '0);

    if (!illegal) begin
      case (op_lo) inside
        OP_NOP: bundle.alu_op = ALU_ADD;
        OP_LW: begin
          bundle.alu_src    = 1'b1;
          bundle.mem_to_reg = 1'b1;
          bundle.alu_op     = ALU_ADD;
          is_load           = 1'b1;
        end
        OP_SW: begin
          bundle.alu_src = 1'b1;
          bundle.alu_op  = ALU_ADD;
          is_store       = 1'b1;
        end
        [OP_RTYPE_LO:OP_RTYPE_HI]: begin
          bundle.reg_dst = 1'b1;
          bundle.alu_op  = ALU_RTYPE;
          is_wb          = 1'b1;
        end
        OP_BEQ: begin
          bundle.alu_op = ALU_SUB;
          is_branch_eq  = 1'b1;
        end
        OP_BNE: begin
          bundle.alu_op = ALU_SUB;
          is_branch_ne  = 1'b1;
        end
        OP_J: is_jump = 1'b1;
        OP_INC: begin
          bundle.alu_src = 1'b1;
          bundle.inc     = 1'b1;
          bundle.alu_op  = ALU_ADD;
          is_wb          = 1'b1;
        end
        OP_DEC: begin
          bundle.alu_src = 1'b1;
          bundle.dec     = 1'b1;
          bundle.alu_op  = ALU_RTYPE;
          is_wb          = 1'b1;
        end
        OP_CLR: begin
          bundle.alu_src = 1'b1;
          bundle.clr     = 1'b1;
          bundle.alu_op  = ALU_RTYPE;
          is_wb          = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory stall timeout,
// illegal-opcode trap and retired-instruction counter.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    instr_count_q;
  trap_cause_t         cause_q;

  ctrl_bundle_t bundle;
  logic is_load, is_store, is_branch_eq, is_branch_ne, is_jump, is_wb, op_q_illegal;
  logic timeout_hit;
  logic opcode_illegal;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .op_q         (op_q),
    .bundle       (bundle),
    .is_load      (is_load),
    .is_store     (is_store),
    .is_branch_eq (is_branch_eq),
    .is_branch_ne (is_branch_ne),
    .is_jump      (is_jump),
    .is_wb        (is_wb),
    .illegal      (op_q_illegal)
  );

  assign timeout_hit    = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign opcode_illegal = illegal_op(bus.opcode[3:0], (bus.opcode >> 4) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= '0;
      wait_cnt      <= '0;
      instr_count_q <= '0;
      cause_q       <= CAUSE_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          if (bus.mem_ready) begin
            state <= S_DECODE;
          end else if (timeout_hit) begin
            state   <= S_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          op_q <= bus.opcode;
          if (opcode_illegal) begin
            state   <= S_TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_q_illegal) begin
            // Unreachable from DECODE; kept so a corrupted op_q halts safely.
            state   <= S_TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end else if (is_load || is_store) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end else if (is_wb) begin
            state <= S_WB;
          end else begin
            state         <= S_FETCH;
            wait_cnt      <= '0;
            instr_count_q <= instr_count_q + CNT_W'(1);
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (is_load) begin
              state <= S_WB;
            end else begin
              state         <= S_FETCH;
              wait_cnt      <= '0;
              instr_count_q <= instr_count_q + CNT_W'(1);
            end
          end else if (timeout_hit) begin
            state   <= S_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          state         <= S_FETCH;
          wait_cnt      <= '0;
          instr_count_q <= instr_count_q + CNT_W'(1);
        end
        default: ;  // S_TRAP holds until reset
      endcase
    end
  end

  // Moore decode from state/op_q; only the FETCH handshake and branch pc_write look at inputs.
  always_comb begin
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_SEQ;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_op     = ALU_RTYPE;
    bus.inc        = 1'b0;
    bus.dec        = 1'b0;
    bus.clr        = 1'b0;
    bus.trap       = 1'b0;

    if (state inside {S_EXEC, S_MEM, S_WB}) begin
      bus.reg_dst    = bundle.reg_dst;
      bus.alu_src    = bundle.alu_src;
      bus.mem_to_reg = bundle.mem_to_reg;
      bus.alu_op     = bundle.alu_op;
      bus.inc        = bundle.inc;
      bus.dec        = bundle.dec;
      bus.clr        = bundle.clr;
    end

    case (state)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_jump) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_JUMP;
        end else if (is_branch_eq) begin
          bus.pc_write = bus.zero;
          bus.pc_src   = PC_BRANCH;
        end else if (is_branch_ne) begin
          bus.pc_write = !bus.zero;
          bus.pc_src   = PC_BRANCH;
        end
      end
      S_MEM: begin
        bus.mem_read  = is_load;
        bus.mem_write = is_store;
      end
      S_WB:   bus.reg_write = 1'b1;
      S_TRAP: bus.trap      = 1'b1;
      default: ;
    endcase
  end

  assign bus.trap_cause  = cause_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: each instruction's observed strobe counts and latency are
// compared against a per-instruction model derived from the opcode classes.
module tb_multicycle_control_unit;
  import ctrl_pkg::*;

  localparam int OPCODE_W    = 6;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;

  typedef struct packed {
    int         cycles;
    int         n_irw;
    int         n_pcw;
    int         n_rd;
    int         n_wr;
    int         n_rw;
    logic [1:0] pcsrc;
    logic [7:0] bundle;
    logic       trapped;
    logic [1:0] cause;
    logic       hung;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(
    .OPCODE_W    (OPCODE_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  function automatic logic [17:0] all_outs();
    return {bus.ir_write, bus.pc_write, bus.pc_src, bus.mem_read, bus.mem_write,
            bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.alu_op,
            bus.inc, bus.dec, bus.clr, bus.trap, bus.trap_cause};
  endfunction

  // Expected per-instruction behaviour for a legal opcode with the given wait counts.
  function automatic obs_t expect_instr(input int op, input logic z, input int fw, input int mw);
    obs_t e;
    bit ld, st, rt, un, j, beq, bne, taken;
    e     = '0;
    ld    = (op == 1);
    st    = (op == 2);
    rt    = (op >= 3 && op <= 8);
    un    = (op >= 12 && op <= 14);
    j     = (op == 11);
    beq   = (op == 9);
    bne   = (op == 10);
    taken = j || (beq && z) || (bne && !z);
    e.cycles = 3 + fw + ((st || rt || un) ? 1 : 0) + (ld ? 2 : 0) + ((ld || st) ? mw : 0);
    e.n_irw  = 1;
    e.n_pcw  = 1 + (taken ? 1 : 0);
    e.n_rd   = 1 + fw + (ld ? 1 + mw : 0);
    e.n_wr   = st ? 1 + mw : 0;
    e.n_rw   = (ld || rt || un) ? 1 : 0;
    e.pcsrc  = j ? 2'b10 : (taken ? 2'b01 : 2'b00);
    case (op) inside
      0:       e.bundle = 8'b0000_0010;
      1:       e.bundle = 8'b0110_0010;
      2:       e.bundle = 8'b0100_0010;
      [3:8]:   e.bundle = 8'b1000_0000;
      9, 10:   e.bundle = 8'b0000_0001;
      12:      e.bundle = 8'b0101_0010;
      13:      e.bundle = 8'b0100_1000;
      14:      e.bundle = 8'b0100_0100;
      default: e.bundle = 8'b0000_0000;
    endcase
    return e;
  endfunction

  // Drive one instruction; memory answers after fw (fetch) / mw (data) wait cycles.
  task automatic run_instr(input logic [OPCODE_W-1:0] op, input logic z, input int fw,
                           input int mw, output obs_t o);
    logic [CNT_W-1:0] base;
    int waits;
    o     = '0;
    base  = bus.instr_count;
    waits = fw;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = 1'b0;
      #1;
      if (bus.trap) begin
        o.trapped = 1'b1;
        o.cause   = bus.trap_cause;
        return;
      end
      if (bus.mem_read || bus.mem_write) begin
        if (waits == 0) begin
          bus.mem_ready = 1'b1;
          waits         = mw;
        end else begin
          waits--;
        end
      end
      #1;
      o.cycles += 1;
      o.n_irw  += int'(bus.ir_write);
      o.n_pcw  += int'(bus.pc_write);
      o.n_rd   += int'(bus.mem_read);
      o.n_wr   += int'(bus.mem_write);
      o.n_rw   += int'(bus.reg_write);
      if (bus.pc_write && !bus.ir_write) o.pcsrc = bus.pc_src;
      o.bundle = {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.inc, bus.dec, bus.clr, bus.alu_op};
      @(posedge clk);
      #1;
      if (bus.instr_count != base) return;
    end
    o.hung = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.opcode    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.opcode    = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({all_outs(), bus.instr_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outs got=%h want=0", {all_outs(), bus.instr_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL idle_outs got=%h want=0", all_outs());
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.mem_read, bus.trap} !== 2'b10) begin
      n_err++;
      $display("FAIL first_fetch got=%b want=10", {bus.mem_read, bus.trap});
    end
    model_cnt = 0;
  endtask

  task automatic test_program();
    int ops[5] = '{0, 3, 1, 2, 11};
    int rw_total = 0;
    obs_t o, e;
    for (int i = 0; i < 5; i++) begin
      run_instr(OPCODE_W'(ops[i]), 1'b0, 0, 0, o);
      e = expect_instr(ops[i], 1'b0, 0, 0);
      model_cnt++;
      rw_total += o.n_rw;
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL program_op%0d got=%p want=%p", ops[i], o, e);
      end
    end
    n_cmp++;
    if ({bus.instr_count, 32'(rw_total)} !== {CNT_W'(5), 32'd2}) begin
      n_err++;
      $display("FAIL program_totals count=%0d rw=%0d want count=5 rw=2", bus.instr_count, rw_total);
    end
  endtask

  task automatic test_branches();
    int   ops[4] = '{9, 9, 10, 10};
    logic zs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    obs_t o, e;
    for (int i = 0; i < 4; i++) begin
      run_instr(OPCODE_W'(ops[i]), zs[i], 0, 0, o);
      e = expect_instr(ops[i], zs[i], 0, 0);
      model_cnt++;
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL branch_op%0d_z%0b got=%p want=%p", ops[i], zs[i], o, e);
      end
    end
  endtask

  task automatic test_wait_states();
    int   ops[3] = '{1, 2, 0};
    int   fws[3] = '{0, 0, MEM_TIMEOUT};
    int   mws[3] = '{3, MEM_TIMEOUT, 0};
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      run_instr(OPCODE_W'(ops[i]), 1'b0, fws[i], mws[i], o);
      e = expect_instr(ops[i], 1'b0, fws[i], mws[i]);
      model_cnt++;
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL wait_op%0d_fw%0d_mw%0d got=%p want=%p", ops[i], fws[i], mws[i], o, e);
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    int op, fw, mw;
    logic z;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 14));
      fw = int'($urandom_range(0, MEM_TIMEOUT));
      mw = int'($urandom_range(0, MEM_TIMEOUT));
      z  = 1'($urandom_range(0, 1));
      run_instr(OPCODE_W'(op), z, fw, mw, o);
      e = expect_instr(op, z, fw, mw);
      model_cnt++;
      n_cmp++;
      if (o !== e || bus.instr_count !== CNT_W'(model_cnt)) begin
        n_err++;
        $display("FAIL random_%0d op=%0d got=%p cnt=%0d want=%p cnt=%0d",
                 i, op, o, bus.instr_count, e, CNT_W'(model_cnt));
      end
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    do_reset();
    for (int i = 0; i < 9; i++) run_instr(OPCODE_W'(0), 1'b0, 0, 0, o);
    n_cmp++;
    if (bus.instr_count !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL wrap_count got=%0d want=1", bus.instr_count);
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    do_reset();
    run_instr(OPCODE_W'(0), 1'b0, 99, 0, o);
    e = '0;
    e.cycles  = MEM_TIMEOUT + 1;
    e.n_rd    = MEM_TIMEOUT + 1;
    e.trapped = 1'b1;
    e.cause   = 2'b10;
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL fetch_timeout got=%p want=%p", o, e);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.zero      = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if ({bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write, bus.reg_write,
           bus.trap, bus.trap_cause, bus.instr_count} !== {5'b0, 1'b1, 2'b10, CNT_W'(0)}) begin
        n_err++;
        $display("FAIL trap_hold_%0d got=%b", i,
                 {bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write, bus.reg_write,
                  bus.trap, bus.trap_cause, bus.instr_count});
      end
    end
    do_reset();
    run_instr(OPCODE_W'(1), 1'b0, 0, 99, o);
    e = expect_instr(1, 1'b0, 0, 0);
    e.cycles  = 3 + MEM_TIMEOUT + 1;
    e.n_rd    = 1 + MEM_TIMEOUT + 1;
    e.n_rw    = 0;
    e.trapped = 1'b1;
    e.cause   = 2'b10;
    n_cmp++;
    if (o !== e || bus.instr_count !== CNT_W'(0)) begin
      n_err++;
      $display("FAIL mem_timeout got=%p cnt=%0d want=%p cnt=0", o, bus.instr_count, e);
    end
  endtask

  task automatic test_illegal();
    logic [OPCODE_W-1:0] bad[2] = '{6'b001111, 6'b010011};
    obs_t o, e;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      run_instr(OPCODE_W'(3), 1'b0, 0, 0, o);
      run_instr(bad[i], 1'b0, 0, 0, o);
      e = '0;
      e.cycles  = 2;
      e.n_irw   = 1;
      e.n_pcw   = 1;
      e.n_rd    = 1;
      e.trapped = 1'b1;
      e.cause   = 2'b01;
      n_cmp++;
      if (o !== e || bus.instr_count !== CNT_W'(1)) begin
        n_err++;
        $display("FAIL illegal_%b got=%p cnt=%0d want=%p cnt=1", bad[i], o, bus.instr_count, e);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    do_reset();
    run_instr(OPCODE_W'(0), 1'b0, 0, 0, o);
    @(negedge clk);
    bus.opcode    = OPCODE_W'(2);
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
    end
    #1;
    n_cmp++;
    if (bus.mem_write !== 1'b1) begin
      n_err++;
      $display("FAIL sw_mem_write got=%b want=1", bus.mem_write);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({all_outs(), bus.instr_count} !== '0) begin
      n_err++;
      $display("FAIL async_drop got=%h want=0", {all_outs(), bus.instr_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL post_reset_idle got=%h want=0", all_outs());
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.mem_read, bus.instr_count} !== {1'b1, CNT_W'(0)}) begin
      n_err++;
      $display("FAIL post_reset_fetch got=%b want=1_000", {bus.mem_read, bus.instr_count});
    end
    model_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_program();
    test_branches();
    test_wait_states();
    test_random();
    test_wrap();
    test_timeout();
    test_illegal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control unit for the 16-bit RISC core: a sequencing state machine that steps each instruction through fetch, decode, execute, memory and write-back. It replaces the single-cycle opcode decode with a parametrised controller that stalls on a memory ready handshake, times out stuck accesses, traps illegal opcodes and counts retired instructions. It sits between the instruction register/memory interface and the datapath muxes, register file and ALU.

## Interface
- OPCODE_W, 4: opcode width; any opcode with bits above [3:0] nonzero is illegal.
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready in FETCH/MEM; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.

- clk  in  1  core clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- opcode  in  OPCODE_W  opcode field from the instruction register; sampled in DECODE.
- mem_ready  in  1  memory handshake; completes the current fetch or data access.
- zero  in  1  ALU zero flag; sampled in EXEC for branches.
- ir_write, pc_write  out  1  instruction register load / PC load.
- pc_src  out  2  00 PC+2, 01 branch target, 10 jump target.
- mem_read, mem_write  out  1  memory strobes.
- reg_write, reg_dst, alu_src, mem_to_reg  out  1  register file / datapath mux controls.
- alu_op  out  2  00 R-type (function from opcode), 01 subtract-compare, 10 add.
- inc, dec, clr  out  1  unary ALU operation selects.
- trap  out  1  controller halted.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- instr_count  out  CNT_W  retired instructions, wrapping.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: all outputs 0; go to FETCH on the first clk after rst_n deasserts.
- FETCH: mem_read=1. When mem_ready=1, ir_write=1, pc_write=1 and pc_src=00 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE: latch opcode into op_q. Opcode 1111, or any upper bit set, goes to TRAP with cause 01. All other opcodes go to EXEC.
- Opcode classes and control bundle in EXEC/MEM/WB (held stable across all three):
  - 0000 NOP: alu_op 10.
  - 0001 LW: alu_src, mem_to_reg, alu_op 10.
  - 0010 SW: alu_src, alu_op 10.
  - 0011-1000 R-type: reg_dst, alu_op 00.
  - 1001 BEQ, 1010 BNE: alu_op 01.
  - 1011 J.
  - 1100 INC: alu_src, inc, alu_op 10.
  - 1101 DEC: alu_src, dec, alu_op 00.
  - 1110 CLR: alu_src, clr, alu_op 00.
- EXEC transitions:
  - NOP goes to FETCH.
  - J: pc_write=1, pc_src=10, then FETCH.
  - BEQ: pc_write=zero, pc_src=01, then FETCH.
  - BNE: pc_write=!zero, pc_src=01, then FETCH.
  - LW and SW go to MEM.
  - R-type, INC, DEC and CLR go to WB.
- MEM: LW holds mem_read and SW holds mem_write until mem_ready. On mem_ready, LW goes to WB and SW goes to FETCH.
- WB: reg_write=1 for exactly one cycle, then FETCH.
- Timeout:
  - wait_cnt clears on entry to FETCH/MEM and increments each cycle there with mem_ready=0.
  - If wait_cnt==MEM_TIMEOUT and mem_ready=0, go to TRAP with cause 10.
  - If mem_ready=1 in that same cycle, the handshake wins.
- TRAP: all strobes 0, trap=1, trap_cause held. Exit only by reset.
- instr_count increments on every transition into FETCH from EXEC, MEM or WB. It wraps at 2^CNT_W-1 → 0. Trapped instructions do not count.

## Timing
- Outputs are Moore-decoded from state and op_q. Exceptions, all combinational in the same cycle: ir_write/pc_write in FETCH (depend on mem_ready) and branch pc_write (depends on zero).
- Reset values: state IDLE, op_q 0, wait_cnt 0, instr_count 0, trap_cause 00. All outputs 0.
- Reset asserted mid-instruction returns to IDLE immediately. Any in-flight strobe drops asynchronously.
- Cycles per instruction with zero-wait memory:
  - NOP, J, BEQ, BNE: 3.
  - SW, R-type, INC, DEC, CLR: 4.
  - LW: 5.
  - Each wait cycle adds 1.
- Worst-case stall before trap: MEM_TIMEOUT+1 cycles in one state.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams;
  - alu_op and pc_src encodings;
  - trap_cause codes;
  - the state enum;
  - a packed struct ctrl_bundle_t {reg_dst, alu_src, mem_to_reg, inc, dec, clr, alu_op}.
- Sub-module ctrl_decode: purely combinational, op_q → ctrl_bundle_t plus class flags (is_load, is_store, is_branch_eq, is_branch_ne, is_jump, is_wb, illegal).
- The top level contains the FSM, wait counter and retire counter.

## Test plan
- Zero-wait program NOP, ADD(0011), LW, SW, J with mem_ready=1 → retirement after 3, 4, 5, 4, 3 cycles; instr_count=5; reg_write high exactly 2 cycles.
- BEQ with zero=1, then BEQ with zero=0, BNE with zero=0 → pc_write/pc_src=01 pulses on 1st and 3rd only.
- LW with mem_ready low for 3 cycles in MEM → mem_read held 4 cycles, then WB; no trap.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → trap=1 and trap_cause=10 after 5 FETCH cycles; strobes 0 thereafter.
- Opcode 1111 → TRAP with cause 01 after DECODE; instr_count unchanged. With OPCODE_W=6, opcode 010011 also traps.
- Assert rst_n low during MEM of SW → mem_write drops without a clock edge; after release: IDLE, then FETCH, counters 0. Separately, CNT_W=3 after 9 retirements → instr_count=1.
